// File: rtl/lfsr_crypt_pkg.sv
// Shared definitions for lfsr_crypt_engine: FSM states, tap ROM, space character
// and the width-generic LFSR step and parity helpers (operands up to FN_W bits).
package lfsr_crypt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        BODY,
        POST,
        DONE
    } state_e;

    localparam int FN_W      = 16;
    localparam int ROM_DEPTH = 9;

    localparam logic [6:0] TAP_ROM [ROM_DEPTH] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // Shift left by one, feeding back the XOR of the tapped bits into bit 0.
    function automatic logic [FN_W-1:0] lfsr_next(input logic [FN_W-1:0] s,
                                                  input logic [FN_W-1:0] taps,
                                                  input int              width);
        logic [FN_W-1:0] mask;
        mask = (FN_W'(1) << width) - FN_W'(1);
        return ((s << 1) | FN_W'(^(s & taps))) & mask;
    endfunction

    function automatic logic [FN_W-1:0] add_parity(input logic [FN_W-1:0] x,
                                                   input int              width);
        logic [FN_W-1:0] body;
        body = x & ((FN_W'(1) << (width - 1)) - FN_W'(1));
        return body | (FN_W'(^body) << (width - 1));
    endfunction

endpackage

// File: rtl/lfsr_crypt_engine_if.sv
// Character stream between the engine and its DMA source / DM1 sink.
// The engine uses the slave modport; the driving side uses master.
interface lfsr_crypt_engine_if #(
    parameter int DATA_W = 8
) ();

    logic [DATA_W-1:0] inData;
    logic              inValid;
    logic              inLast;
    logic              inReady;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic              outReady;

    modport master (
        output inData, inValid, inLast, outReady,
        input  inReady, outData, outValid
    );

    modport slave (
        input  inData, inValid, inLast, outReady,
        output inReady, outData, outValid
    );

endinterface

// File: rtl/lfsr_crypt_engine_lfsr_gen.sv
// Keystream LFSR: loads a seed (zero replaced by one) and steps once per enable.
module lfsr_gen
    import lfsr_crypt_pkg::*;
#(
    parameter int LFSR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              step_i,
    input  logic [LFSR_W-1:0] taps_i,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? LFSR_W'(1) : seed_i;
        end else if (step_i) begin
            state_d = LFSR_W'(lfsr_next(FN_W'(state_q), FN_W'(taps_i), LFSR_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LFSR_W'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/lfsr_crypt_engine.sv
// LFSR stream-cipher coprocessor: space preamble, XOR body, space padding, parity MSB.
// Define LFSR_CUSTOM_TAP_EN to take taps from the taps_i port instead of the ROM.
module lfsr_crypt_engine
    import lfsr_crypt_pkg::*;
#(
    parameter int LFSR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int MSG_LEN = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 mode_i,
`ifdef LFSR_CUSTOM_TAP_EN
    input  logic [LFSR_W-1:0]    taps_i,
`else
    input  logic [3:0]           ptrnSel_i,
`endif
    input  logic [LFSR_W-1:0]    seed_i,
    input  logic [7:0]           preLen_i,
    lfsr_crypt_engine_if.slave   stream,
    output logic                 ack_o,
    output logic [7:0]           errCnt_o,
    output logic                 ptrnErr_o
);

    localparam int               POS_W   = $clog2(MSG_LEN + 1);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(MSG_LEN);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    if (LFSR_W > DATA_W - 1 || DATA_W > FN_W) begin : g_badWidth
        $error("lfsr_crypt_engine: need LFSR_W <= DATA_W-1 and DATA_W <= 16");
    end
`ifndef LFSR_CUSTOM_TAP_EN
    if (LFSR_W != 7) begin : g_badRom
        $error("lfsr_crypt_engine: tap ROM entries require LFSR_W == 7");
    end
`endif

    state_e              state_q, state_d;
    logic                mode_q;
    logic [LFSR_W-1:0]   taps_q;
    logic [POS_W-1:0]    preLim_q;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [DATA_W-1:0]   outData_q, outData_d;
    logic                outValid_q, outValid_d;
    logic [7:0]          errCnt_q, errCnt_d;
    logic                ptrnErr_q, ptrnErr_d;

    logic                cfgLoad, emit, inReady, ack, slotFree, room;
    logic [DATA_W-1:0]   emitChar;
    logic [LFSR_W-1:0]   lfsrState, startTaps;
    logic [DATA_W-1:0]   lfsrExt;
    logic [POS_W-1:0]    startPreLim;
    logic                startPtrnErr;

    function automatic logic [DATA_W-1:0] encChar(input logic [DATA_W-1:0] c,
                                                  input logic [LFSR_W-1:0] key);
        return DATA_W'(add_parity(FN_W'(c ^ DATA_W'(key)), DATA_W));
    endfunction

    // Configuration decoded from the inputs, captured only when a frame starts.
`ifdef LFSR_CUSTOM_TAP_EN
    assign startTaps    = taps_i;
    assign startPtrnErr = 1'b0;
`else
    logic [3:0] tapIdx;
    assign startPtrnErr = (ptrnSel_i > 4'd8);
    assign tapIdx       = startPtrnErr ? 4'd0 : ptrnSel_i;
    assign startTaps    = LFSR_W'(TAP_ROM[tapIdx]);
`endif

    assign startPreLim = (32'(preLen_i) >= MSG_LEN) ? POS_MAX : POS_W'(preLen_i);
    assign lfsrExt     = DATA_W'(lfsrState);
    assign slotFree    = !outValid_q || stream.outReady;
    assign room        = slotFree && (pos_q != POS_MAX);

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        outData_d  = outData_q;
        outValid_d = outValid_q && !stream.outReady;
        errCnt_d   = errCnt_q;
        ptrnErr_d  = ptrnErr_q;
        cfgLoad    = 1'b0;
        inReady    = 1'b0;
        emit       = 1'b0;
        emitChar   = '0;
        ack        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    cfgLoad   = 1'b1;
                    pos_d     = '0;
                    errCnt_d  = '0;
                    ptrnErr_d = startPtrnErr;
                    state_d   = (!mode_i && preLen_i != 8'd0) ? PRE : BODY;
                end
            end
            PRE: begin
                if (room) begin
                    emit     = 1'b1;
                    emitChar = encChar(DATA_W'(SPACE_CHAR), lfsrState);
                    if (pos_q + POS_ONE == preLim_q) state_d = BODY;
                end
            end
            BODY: begin
                if (mode_q) begin
                    inReady = room;
                    if (room && stream.inValid) begin
                        emit     = 1'b1;
                        emitChar = {1'b0, stream.inData[DATA_W-2:0] ^ lfsrExt[DATA_W-2:0]};
                        if ((stream.inData[DATA_W-1] != ^stream.inData[DATA_W-2:0]) &&
                            (errCnt_q != 8'hFF)) begin
                            errCnt_d = errCnt_q + 8'd1;
                        end
                    end
                end else if (pos_q == POS_MAX) begin
                    state_d = POST;
                end else begin
                    inReady = room;
                    if (room && stream.inValid) begin
                        emit     = 1'b1;
                        emitChar = encChar(stream.inData, lfsrState);
                        if (stream.inLast || (pos_q + POS_ONE == POS_MAX)) state_d = POST;
                    end
                end
            end
            POST: begin
                if (room) begin
                    emit     = 1'b1;
                    emitChar = encChar(DATA_W'(SPACE_CHAR), lfsrState);
                end
            end
            DONE: begin
                ack = 1'b1;
                if (!start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (emit) begin
            outData_d  = emitChar;
            outValid_d = 1'b1;
            pos_d      = pos_q + POS_ONE;
        end
        // The frame ends on the transfer of the final character, whatever state generated it.
        if (outValid_q && stream.outReady && pos_q == POS_MAX) state_d = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            taps_q     <= '0;
            preLim_q   <= '0;
            pos_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            errCnt_q   <= '0;
            ptrnErr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            errCnt_q   <= errCnt_d;
            ptrnErr_q  <= ptrnErr_d;
            if (cfgLoad) begin
                mode_q   <= mode_i;
                taps_q   <= startTaps;
                preLim_q <= startPreLim;
            end
        end
    end

    lfsr_gen #(
        .LFSR_W (LFSR_W)
    ) u_lfsrGen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (cfgLoad),
        .seed_i  (seed_i),
        .step_i  (emit),
        .taps_i  (cfgLoad ? startTaps : taps_q),
        .state_o (lfsrState)
    );

    assign stream.inReady  = inReady;
    assign stream.outData  = outData_q;
    assign stream.outValid = outValid_q;
    assign ack_o           = ack;
    assign errCnt_o        = errCnt_q;
    assign ptrnErr_o       = ptrnErr_q;

endmodule

// File: tb/tb_lfsr_crypt_engine.sv
// Self-checking bench for lfsr_crypt_engine: a frame-level software model builds the
// expected 64-character frame, and a negedge monitor compares every output transfer.
module tb_lfsr_crypt_engine;

    localparam int LFSR_W  = 7;
    localparam int DATA_W  = 8;
    localparam int MSG_LEN = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] ptrnSel = 4'd0;
    logic [6:0] seed = 7'd0;
    logic [6:0] tbTaps = 7'h60;
    logic [7:0] preLen = 8'd0;
    logic       ack;
    logic [7:0] errCnt;
    logic       ptrnErr;

    lfsr_crypt_engine_if #(.DATA_W(DATA_W)) bus ();

    always #5 clk = ~clk;

    lfsr_crypt_engine #(
        .LFSR_W  (LFSR_W),
        .DATA_W  (DATA_W),
        .MSG_LEN (MSG_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .mode_i    (mode),
`ifdef LFSR_CUSTOM_TAP_EN
        .taps_i    (tbTaps),
`else
        .ptrnSel_i (ptrnSel),
`endif
        .seed_i    (seed),
        .preLen_i  (preLen),
        .stream    (bus),
        .ack_o     (ack),
        .errCnt_o  (errCnt),
        .ptrnErr_o (ptrnErr)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] romTaps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
    logic [7:0] pinOut  [7] = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, 8'hE1};
    logic [6:0] pinLfsr [7] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41};

    logic [7:0] bodyQ[$];
    logic [7:0] expOut [MSG_LEN];
    logic [7:0] encFrame [MSG_LEN];
    int         expErr, expConsumed, expPtrnErr;
    int         outIdx = 0;
    logic       monActive = 1'b0;
    logic       prevHold = 1'b0;
    logic [7:0] prevData = 8'h00;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [6:0] modelStep(input logic [6:0] s, input logic [6:0] t);
        int fb;
        fb = $countones(s & t) % 2;
        return 7'(((int'(s) * 2) % 128) + fb);
    endfunction

    // Software reference: lays out the whole frame as characters, then XORs with the keystream.
    task automatic buildExpected(input bit m, input logic [6:0] taps, input logic [6:0] sd, input int pl);
        logic [7:0] chars[$];
        logic [6:0] s, x;
        int         pre, n;
        s      = (sd == 7'd0) ? 7'd1 : sd;
        expErr = 0;
        if (!m) begin
            pre = (pl > MSG_LEN) ? MSG_LEN : pl;
            repeat (pre) chars.push_back(8'h20);
            n = bodyQ.size();
            if (n > MSG_LEN - pre) n = MSG_LEN - pre;
            for (int i = 0; i < n; i++) chars.push_back(bodyQ[i]);
            while (chars.size() < MSG_LEN) chars.push_back(8'h20);
            expConsumed = n;
        end else begin
            for (int i = 0; i < MSG_LEN; i++) chars.push_back(bodyQ[i]);
            expConsumed = MSG_LEN;
        end
        for (int k = 0; k < MSG_LEN; k++) begin
            x = chars[k][6:0] ^ s;
            if (!m) begin
                expOut[k] = {1'($countones(x) % 2), x};
            end else begin
                expOut[k] = {1'b0, x};
                if (chars[k][7] != ($countones(chars[k][6:0]) % 2 == 1)) expErr++;
            end
            s = modelStep(s, taps);
        end
    endtask

    // Output monitor: every transfer against the model, plus stability while stalled.
    always @(negedge clk) begin
        if (monActive) begin
            if (prevHold) begin
                checkOutput("holdValid", int'(bus.outValid), 1);
                checkOutput("holdData", int'(bus.outData), int'(prevData));
            end
            if (bus.outValid && bus.outReady) begin
                if (outIdx < MSG_LEN) checkOutput($sformatf("out[%0d]", outIdx), int'(bus.outData), int'(expOut[outIdx]));
                else checkOutput("extraOutputIndex", outIdx, MSG_LEN - 1);
                outIdx++;
            end
            prevHold = bus.outValid && !bus.outReady;
            prevData = bus.outData;
        end else begin
            prevHold = 1'b0;
        end
    end

    task automatic applyStimulus(input bit m, input int sel, input logic [6:0] sd, input int pl,
                                 input bit stalls, input bit timing, input int abortAt);
        int cyc, firstValid, ackCyc, inIdx;
        tbTaps = romTaps[(sel > 8) ? 0 : sel];
`ifdef LFSR_CUSTOM_TAP_EN
        expPtrnErr = 0;
`else
        expPtrnErr = (sel > 8) ? 1 : 0;
`endif
        buildExpected(m, tbTaps, sd, pl);
        @(posedge clk); #1;
        start = 1'b1; mode = m; ptrnSel = 4'(sel); seed = sd; preLen = 8'(pl);
        bus.inValid = 1'b0; bus.inLast = 1'b0; bus.outReady = 1'b1;
        outIdx = 0; inIdx = 0; monActive = 1'b1;
        firstValid = -1; ackCyc = -1; cyc = 0;
        while (cyc < 2000) begin
            @(negedge clk); #1;
            if (bus.outValid && firstValid < 0) firstValid = cyc;
            if (ack) begin
                ackCyc = cyc;
                break;
            end
            if (bus.inValid && bus.inReady) inIdx++;
            if (abortAt >= 0 && outIdx >= abortAt) break;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            bus.outReady = stalls ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (inIdx < bodyQ.size() && (!stalls || $urandom_range(0, 3) != 0)) begin
                bus.inValid = 1'b1;
                bus.inData  = bodyQ[inIdx];
                bus.inLast  = (inIdx == bodyQ.size() - 1);
            end else begin
                bus.inValid = 1'b0;
                bus.inLast  = 1'b0;
            end
        end
        if (abortAt >= 0) begin
            monActive = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            checkOutput("abortOutValid", int'(bus.outValid), 0);
            checkOutput("abortOutData", int'(bus.outData), 0);
            checkOutput("abortInReady", int'(bus.inReady), 0);
            checkOutput("abortAck", int'(ack), 0);
            checkOutput("abortErrCnt", int'(errCnt), 0);
            bus.inValid = 1'b0; bus.inLast = 1'b0;
            @(negedge clk); rst_n = 1'b1;
            repeat (3) @(negedge clk);
            checkOutput("idleAfterAbort", int'({bus.outValid, bus.inReady, ack}), 0);
            return;
        end
        checkOutput("ackSeen", int'(ackCyc >= 0), 1);
        checkOutput("outCount", outIdx, MSG_LEN);
        checkOutput("errCnt", int'(errCnt), expErr);
        checkOutput("inputsConsumed", inIdx, expConsumed);
        checkOutput("inReadyInDone", int'(bus.inReady), 0);
        checkOutput("ptrnErr", int'(ptrnErr), expPtrnErr);
        if (timing) begin
            checkOutput("firstValidCycle", firstValid, 2);
            checkOutput("ackCycle", ackCyc, MSG_LEN + 2);
        end
        monActive = 1'b0;
        bus.inValid = 1'b0; bus.inLast = 1'b0;
        @(negedge clk);
        checkOutput("ackDropsWhenStartLow", int'(ack), 0);
    endtask

    initial begin
        string      msg;
        logic [6:0] s;
        int         nonSpace;
        msg = "Mr. Watson, come here. I want to see you.";
        bus.inData = '0; bus.inValid = 1'b0; bus.inLast = 1'b0; bus.outReady = 1'b1;

        #2;
        checkOutput("resetOutValid", int'(bus.outValid), 0);
        checkOutput("resetOutData", int'(bus.outData), 0);
        checkOutput("resetInReady", int'(bus.inReady), 0);
        checkOutput("resetAck", int'(ack), 0);
        checkOutput("resetErrCnt", int'(errCnt), 0);
        checkOutput("resetPtrnErr", int'(ptrnErr), 0);
        @(negedge clk); rst_n = 1'b1;

        // Reference frame: all-space body, hand-computed keystream and first outputs.
        s = 7'h01;
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("modelLfsr[%0d]", i), int'(s), int'(pinLfsr[i]));
            s = modelStep(s, 7'h60);
        end
        bodyQ.delete();
        repeat (20) bodyQ.push_back(8'h20);
        buildExpected(1'b0, 7'h60, 7'h01, 10);
        for (int i = 0; i < 7; i++) checkOutput($sformatf("modelOut[%0d]", i), int'(expOut[i]), int'(pinOut[i]));
        applyStimulus(1'b0, 0, 7'h01, 10, 1'b0, 1'b1, -1);
        for (int i = 0; i < MSG_LEN; i++) encFrame[i] = expOut[i];

        $display("[TB] decrypt of reference frame");
        bodyQ.delete();
        for (int i = 0; i < MSG_LEN; i++) bodyQ.push_back(encFrame[i]);
        buildExpected(1'b1, 7'h60, 7'h01, 0);
        nonSpace = 0;
        for (int i = 0; i < MSG_LEN; i++) if (expOut[i] != 8'h20) nonSpace++;
        checkOutput("modelDecryptSpaces", nonSpace, 0);
        applyStimulus(1'b1, 0, 7'h01, 0, 1'b0, 1'b0, -1);

        $display("[TB] decrypt with three parity faults");
        bodyQ[3] ^= 8'h80; bodyQ[17] ^= 8'h80; bodyQ[50] ^= 8'h80;
        buildExpected(1'b1, 7'h60, 7'h01, 0);
        checkOutput("modelErr3", expErr, 3);
        applyStimulus(1'b1, 0, 7'h01, 0, 1'b1, 1'b0, -1);

        $display("[TB] encrypt message, random config");
        bodyQ.delete();
        for (int i = 0; i < msg.len(); i++) bodyQ.push_back(msg[i]);
        for (int r = 0; r < 2; r++)
            applyStimulus(1'b0, $urandom_range(0, 8), 7'($urandom_range(0, 127)), $urandom_range(10, 15), 1'b0, 1'b0, -1);

        $display("[TB] truncation: long preamble");
        bodyQ.delete();
        repeat (30) bodyQ.push_back(8'($urandom_range(0, 255)));
        applyStimulus(1'b0, 3, 7'h55, 40, 1'b0, 1'b0, -1);
        checkOutput("truncConsumed24", expConsumed, 24);

        $display("[TB] seed zero with stalls and gaps");
        applyStimulus(1'b0, 5, 7'h00, 7, 1'b1, 1'b0, -1);

        $display("[TB] random decrypt frames");
        for (int r = 0; r < 2; r++) begin
            bodyQ.delete();
            repeat (MSG_LEN) bodyQ.push_back(8'($urandom_range(0, 255)));
            applyStimulus(1'b1, $urandom_range(0, 8), 7'($urandom_range(0, 127)), 0, 1'b1, 1'b0, -1);
        end

        $display("[TB] reset mid-frame");
        bodyQ.delete();
        for (int i = 0; i < msg.len(); i++) bodyQ.push_back(msg[i]);
        applyStimulus(1'b0, 2, 7'h33, 12, 1'b1, 1'b0, 20);

        $display("[TB] out-of-range tap pattern");
        applyStimulus(1'b0, 12, 7'h2A, 11, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_crypt_engine.md
# lfsr_crypt_engine

Hardware LFSR stream-cipher engine, the successor to the software encryption program (Program #1) that runs on TopLevel. It encrypts or decrypts a message over a byte stream. Encryption covers space preamble, body XOR LFSR, space post-padding and a parity MSB. Decryption covers the parity check and XOR. LFSR width, character width, frame length and tap source are parametrised. It sits beside the processor core as a stream coprocessor between data memory DMA and DM1.

## Interface
- LFSR_W, 7, LFSR width; must be ≤ DATA_W-1
- DATA_W, 8, character width; MSB carries parity
- MSG_LEN, 64, output frame length in characters
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  level; sampled only in IDLE
- Mode  in  1  0 = encrypt, 1 = decrypt; latched at start
- PtrnSel  in  4  tap-pattern index 0..8; latched at start
- Seed  in  LFSR_W  initial LFSR state; latched at start
- PreLen  in  8  preamble length, encrypt only; latched at start
- InData  in  DATA_W  input character
- InValid  in  1  InData valid
- InLast  in  1  marks final body character, encrypt only
- InReady  out  1  engine accepts InData this cycle
- OutData  out  DATA_W  output character, registered
- OutValid  out  1  OutData valid
- OutReady  in  1  downstream accepts
- Ack  out  1  frame complete
- ErrCnt  out  8  decrypt parity-error count, saturating
- PtrnErr  out  1  PtrnSel > 8 seen at start

## Operation
- FSM states: IDLE, PRE, BODY, POST, DONE.
- IDLE with Start=1: latch the configuration into registers and clear pos, ErrCnt and PtrnErr.
  - Encrypt: go to PRE, or BODY if PreLen=0.
  - Decrypt: go to BODY.
- LFSR step: next = {lfsr[LFSR_W-2:0], ^(lfsr & taps)}. Seed=0 is replaced by 1.
- The LFSR advances exactly once per output character, on each output transfer.
- Taps: 9-entry ROM 0x60,0x48,0x78,0x72,0x6A,0x69,0x5C,0x7E,0x7B, indexed by PtrnSel. Index >8 uses entry 0 and sets PtrnErr.
- Encrypt character c: x = c ^ zero-extended lfsr; out = {^x[DATA_W-2:0], x[DATA_W-2:0]}. The input MSB is ignored.
- PRE: emits encrypt(0x20); no input consumed; after min(PreLen, MSG_LEN) characters go to BODY.
- BODY, encrypt mode:
  - InReady=1 while the output slot is free.
  - An accepted InData is emitted encrypted.
  - InLast accepted, or pos reaching MSG_LEN, leaves BODY.
  - Leaving at MSG_LEN truncates the message: later input is not consumed.
- POST: emits encrypt(0x20) until pos = MSG_LEN.
- BODY, decrypt mode:
  - Consumes exactly MSG_LEN characters.
  - out = {1'b0, InData[DATA_W-2:0] ^ lfsr}.
  - ErrCnt increments (saturating at 255) when InData[DATA_W-1] != ^InData[DATA_W-2:0].
  - InLast is ignored.
- pos counts output transfers, width $clog2(MSG_LEN+1). After the MSG_LEN-th output transfer go to DONE.
- DONE: Ack=1 and InReady=0. Leave to IDLE when Start=0; Start held high keeps DONE.
- Start outside IDLE is ignored.

## Timing
- Reset values: OutValid=0, OutData=0, InReady=0, Ack=0, ErrCnt=0, PtrnErr=0, state IDLE.
- Reset mid-frame aborts immediately; no partial flush.
- Output register advances when !OutValid || OutReady.
- Latency: an accepted input appears on OutData one cycle later.
- Generated padding (PRE/POST) is produced one character per cycle when OutReady=1.
- OutData and OutValid are held stable while OutValid && !OutReady.
- InReady is combinational from state and the output-slot condition; the transfer happens when InValid && InReady.
- Start=1 in IDLE gives the first OutValid 2 cycles later in PRE.
- Ack rises the cycle after the last output transfer.
- Full frame, no stalls: MSG_LEN + 2 cycles from Start to Ack.

## Configuration
- LFSR_CUSTOM_TAP_EN defined:
  - Adds port Taps, in, LFSR_W, latched at start.
  - The ROM and PtrnSel are removed; PtrnErr is tied to 0.
- LFSR_CUSTOM_TAP_EN undefined: ROM taps only. ROM entries require LFSR_W=7; otherwise elaboration fails.

## Structure
- Package lfsr_crypt_pkg holds:
  - the state enum;
  - the tap ROM constant array;
  - SPACE_CHAR = 8'h20;
  - functions lfsr_next and add_parity.
- One sub-module, lfsr_gen (state register, load, step enable, taps input), is natural. The FSM and datapath stay in the top.

## Test plan
- Encrypt, PtrnSel=0, Seed=0x01, PreLen=10, OutReady=1:
  - LFSR sequence 01,02,04,08,10,20,41.
  - Outputs 0..6 = 0x21,0x22,0x24,0x28,0x30,0x00,0xE1.
  - Ack after 64 characters.
- Encrypt "Mr. Watson, come here. I want to see you.", random PtrnSel/Seed/PreLen 10..15: all 64 bytes match the software reference model.
- PreLen=40, 30-char body: exactly 24 body characters consumed, then InReady=0, then Ack.
- Decrypt the first test's 64-byte output: 64× 0x20, ErrCnt=0.
- Decrypt with bit 7 flipped on 3 bytes: ErrCnt=3, data unchanged.
- Random OutReady stalls and InValid gaps with Seed=0: output equals the Seed=1 run. Reset low at character 20: outputs zero and FSM IDLE immediately. PtrnSel=12 sets PtrnErr and uses taps 0x60.
